// File: rtl/imem_pkg.sv
// Shared constants and FSM state type for the instruction-memory loader.
package imem_pkg;

  localparam int          DEPTH     = 16;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Loader byte stream, fetch port and status signals between host/core and imem_loader.
interface imem_loader_if;

  logic        load_start;
  logic [4:0]  word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        cpu_hold;
  logic        load_done;
  logic [7:0]  checksum;

  modport master (
    output load_start, word_count, byte_valid, byte_data, fetch_addr,
    input  byte_ready, fetch_instr, cpu_hold, load_done, checksum
  );

  modport slave (
    input  load_start, word_count, byte_valid, byte_data, fetch_addr,
    output byte_ready, fetch_instr, cpu_hold, load_done, checksum
  );

endinterface

// File: rtl/imem_word_packer.sv
// Packs accepted bytes little-endian into 32-bit words; strobes on the fourth byte.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  input  logic        clear_i,
  output logic [31:0] word_o,
  output logic        word_strobe_o
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;

  // The fourth byte completes the word directly from the input, so it is
  // available for a write at the same edge it is accepted.
  assign word_o        = {byte_i, acc_q};
  assign word_strobe_o = accept_i && (idx_q == 2'd3);

  // Next byte index and partial-word accumulator.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    idx_d = idx_q;
    acc_d = acc_q;
    if (clear_i) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accept_i) begin
      unique case (idx_q)
        2'd0:    acc_d[7:0]   = byte_i;
        2'd1:    acc_d[15:8]  = byte_i;
        2'd2:    acc_d[23:16] = byte_i;
        default: acc_d        = acc_q;
      endcase
      idx_d = idx_q + 2'd1;
    end
  end

  // Packer state register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Instruction memory that is filled from a byte stream while the core is held,
// and read by the fetch stage with one cycle of latency.
module imem_loader #(
  parameter int          DEPTH     = imem_pkg::DEPTH,
  parameter logic [31:0] NOP_INSTR = imem_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  imem_loader_if.slave bus
);

  import imem_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_lat_q, cnt_lat_d;
  logic [CW-1:0]   word_addr_q, word_addr_d;
  logic [CW-1:0]   cnt_clamped;
  logic [7:0]      checksum_q, checksum_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     fetch_instr_q;
  logic            byte_ready;
  logic            accept;
  logic            clear;
  logic            load_done;
  logic [31:0]     pack_word;
  logic            pack_strobe;

  // Fetch ignores the byte offset and the high address bits.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.fetch_addr[31:AW+2], bus.fetch_addr[1:0],
                              word_addr_q[CW-1:AW]};

  assign byte_ready = (state_q == LOAD);
  assign accept     = bus.byte_valid && byte_ready;

  imem_word_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .byte_i        (bus.byte_data),
    .accept_i      (accept),
    .clear_i       (clear),
    .word_o        (pack_word),
    .word_strobe_o (pack_strobe)
  );

  // Requested word count, saturated at the memory depth.
  always_comb begin
    cnt_clamped = CW'(bus.word_count);
    if (int'(bus.word_count) > DEPTH) cnt_clamped = CW'(DEPTH);
  end

  // FSM next state, load bookkeeping and status outputs.
  always_comb begin
    state_d     = state_q;
    cnt_lat_d   = cnt_lat_q;
    word_addr_d = word_addr_q;
    checksum_d  = checksum_q;
    clear       = 1'b0;
    load_done   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          clear       = 1'b1;
          cnt_lat_d   = cnt_clamped;
          word_addr_d = '0;
          checksum_d  = '0;
          state_d     = (cnt_clamped == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) checksum_d = checksum_q ^ bus.byte_data;
        if (pack_strobe) begin
          word_addr_d = word_addr_q + CW'(1);
          if (word_addr_q + CW'(1) == cnt_lat_q) state_d = DONE;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and load bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_lat_q   <= '0;
      word_addr_q <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_lat_q   <= cnt_lat_d;
      word_addr_q <= word_addr_d;
      checksum_q  <= checksum_d;
    end
  end

  // Word storage and registered fetch; a same-edge write is seen one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the array is built from flops rather than a RAM macro because reset
    // must NOP-fill every entry at once.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= NOP_INSTR;
      fetch_instr_q <= '0;
    end else begin
      fetch_instr_q <= mem_q[bus.fetch_addr[AW+1:2]];
      if (pack_strobe) mem_q[word_addr_q[AW-1:0]] <= pack_word;
    end
  end

  assign bus.byte_ready  = byte_ready;
  assign bus.fetch_instr = fetch_instr_q;
  assign bus.cpu_hold    = (state_q != IDLE);
  assign bus.load_done   = load_done;
  assign bus.checksum    = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-vector bench for imem_loader.
module tb_imem_loader;

  import imem_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_pulses = 0;

  always #5 clk = ~clk;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(16), .NOP_INSTR(NOP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Counts cycles in which load_done was high.
  always @(posedge clk) if (bus.load_done === 1'b1) done_pulses++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, output logic [31:0] val);
    bus.fetch_addr = addr;
    step();
    val = bus.fetch_instr;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    step();
    bus.byte_valid = 1'b0;
  endtask

  task automatic start_load(input logic [4:0] wc);
    bus.load_start = 1'b1;
    bus.word_count = wc;
    step();
    bus.load_start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.fetch_instr !== 32'h0 || bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b0 ||
        bus.load_done !== 1'b0 || bus.checksum !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: instr=%h ready=%b hold=%b done=%b csum=%h, want 0 0 0 0 0",
               bus.fetch_instr, bus.byte_ready, bus.cpu_hold, bus.load_done, bus.checksum);
    end
    n_checks++;
    if (dut.state_q !== IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %0d want IDLE", dut.state_q);
    end
    reset = 1'b0;
    fetch(32'h8, v);
    n_checks++;
    if (v !== NOP || bus.cpu_hold !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_fetch: instr=%h hold=%b want %h 0", v, bus.cpu_hold, NOP);
    end
  endtask

  task automatic test_basic_load();
    logic [7:0]  bytes [8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    logic [7:0]  exp_csum = 8'h93 ^ 8'h00 ^ 8'h10 ^ 8'h00 ^ 8'h13 ^ 8'h01 ^ 8'h20 ^ 8'h00;
    logic [31:0] v;
    int          d0 = done_pulses;
    start_load(5'd2);
    n_checks++;
    if (bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_entry: hold=%b ready=%b want 1 1", bus.cpu_hold, bus.byte_ready);
    end
    for (int i = 0; i < 8; i++) begin
      bus.fetch_addr = 32'h0;
      send_byte(bytes[i]);
      if (i == 3) begin
        n_checks++;
        if (bus.fetch_instr !== NOP) begin
          n_fail++;
          $display("FAIL read_before_write: got %h want %h", bus.fetch_instr, NOP);
        end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.fetch_instr !== 32'h0010_0093) begin
          n_fail++;
          $display("FAIL read_after_write: got %h want 00100093", bus.fetch_instr);
        end
      end
    end
    n_checks++;
    if (bus.load_done !== 1'b1 || bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL done_state: done=%b ready=%b hold=%b want 1 0 1",
               bus.load_done, bus.byte_ready, bus.cpu_hold);
    end
    step();
    n_checks++;
    if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b0 || done_pulses - d0 != 1) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b hold=%b pulses=%0d want 0 0 1",
               bus.load_done, bus.cpu_hold, done_pulses - d0);
    end
    fetch(32'h0, v);
    n_checks++;
    if (v !== 32'h0010_0093) begin n_fail++; $display("FAIL basic_mem0: got %h want 00100093", v); end
    fetch(32'hFFFF_FFC7, v);
    n_checks++;
    if (v !== 32'h0020_0113) begin n_fail++; $display("FAIL basic_mem1_alias: got %h want 00200113", v); end
    fetch(32'h8, v);
    n_checks++;
    if (v !== NOP) begin n_fail++; $display("FAIL basic_mem2_kept: got %h want %h", v, NOP); end
    n_checks++;
    if (bus.checksum !== exp_csum) begin
      n_fail++;
      $display("FAIL basic_checksum: got %h want %h", bus.checksum, exp_csum);
    end
  endtask

  task automatic test_gapped_load();
    logic [7:0]  bytes [8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    logic [31:0] exp [3] = '{32'h0010_0093, 32'h0020_0113, NOP};
    logic [31:0] v;
    int          hold_low = 0;
    do_reset();
    start_load(5'd2);
    for (int i = 0; i < 8; i++) begin
      if (bus.cpu_hold !== 1'b1) hold_low++;
      send_byte(bytes[i]);
      if (i != 7) begin
        if (bus.cpu_hold !== 1'b1) hold_low++;
        step();
      end
    end
    if (bus.cpu_hold !== 1'b1) hold_low++;
    n_checks++;
    if (hold_low != 0 || bus.load_done !== 1'b1) begin
      n_fail++;
      $display("FAIL gapped_hold: low_cycles=%0d done=%b want 0 1", hold_low, bus.load_done);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      fetch(32'(i * 4), v);
      n_checks++;
      if (v !== exp[i]) begin n_fail++; $display("FAIL gapped_mem%0d: got %h want %h", i, v, exp[i]); end
    end
  endtask

  task automatic test_zero_count();
    logic [31:0] v;
    start_load(5'd0);
    n_checks++;
    if (bus.load_done !== 1'b1 || bus.cpu_hold !== 1'b1 || bus.byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b hold=%b ready=%b want 1 1 0",
               bus.load_done, bus.cpu_hold, bus.byte_ready);
    end
    step();
    n_checks++;
    if (bus.load_done !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.checksum !== 8'h0) begin
      n_fail++;
      $display("FAIL zero_idle: done=%b hold=%b csum=%h want 0 0 00",
               bus.load_done, bus.cpu_hold, bus.checksum);
    end
    fetch(32'h0, v);
    n_checks++;
    if (v !== 32'h0010_0093) begin n_fail++; $display("FAIL zero_no_write: got %h want 00100093", v); end
  endtask

  task automatic test_full_load();
    logic [31:0] v, e;
    logic [7:0]  exp_csum = 8'h0;
    int          d0 = done_pulses;
    do_reset();
    start_load(5'd20);
    for (int k = 0; k < 64; k++) begin
      if (k == 20) begin
        bus.load_start = 1'b1;
        bus.word_count = 5'd1;
        step();
        bus.load_start = 1'b0;
        n_checks++;
        if (bus.byte_ready !== 1'b1 || dut.state_q !== LOAD) begin
          n_fail++;
          $display("FAIL ignore_start: ready=%b state=%0d want 1 LOAD", bus.byte_ready, dut.state_q);
        end
      end
      exp_csum ^= pat(k);
      send_byte(pat(k));
      if (k == 62) begin
        n_checks++;
        if (bus.load_done !== 1'b0 || bus.byte_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL full_early_done: done=%b ready=%b want 0 1", bus.load_done, bus.byte_ready);
        end
      end
    end
    n_checks++;
    if (bus.load_done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", bus.load_done); end
    step();
    n_checks++;
    if (done_pulses - d0 != 1 || bus.checksum !== exp_csum) begin
      n_fail++;
      $display("FAIL full_summary: pulses=%0d csum=%h want 1 %h", done_pulses - d0, bus.checksum, exp_csum);
    end
    for (int i = 0; i < 16; i++) begin
      e = {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)};
      fetch(32'(i * 4), v);
      n_checks++;
      if (v !== e) begin n_fail++; $display("FAIL full_mem%0d: got %h want %h", i, v, e); end
    end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] v;
    start_load(5'd4);
    for (int k = 0; k < 6; k++) send_byte(8'hA0 + 8'(k));
    reset = 1'b1;
    #1;
    n_checks++;
    if (dut.state_q !== IDLE || bus.byte_ready !== 1'b0 || bus.cpu_hold !== 1'b0 ||
        bus.fetch_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_state: state=%0d ready=%b hold=%b instr=%h want IDLE 0 0 0",
               dut.state_q, bus.byte_ready, bus.cpu_hold, bus.fetch_instr);
    end
    step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      fetch(32'(i * 4), v);
      n_checks++;
      if (v !== NOP) begin n_fail++; $display("FAIL midreset_mem%0d: got %h want %h", i, v, NOP); end
    end
    start_load(5'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    step();
    fetch(32'h0, v);
    n_checks++;
    if (v !== 32'h4433_2211) begin n_fail++; $display("FAIL midreset_repack: got %h want 44332211", v); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.load_start = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    bus.fetch_addr = '0;
    test_reset();
    test_basic_load();
    test_gapped_load();
    test_zero_count();
    test_full_load();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
